// File: rtl/perm5_if.sv
// perm5_if: valid/ready handshake bundle for the PERM5 permutation engine.
// The input side carries a 5-bit word and its 14-bit control word. The output
// side carries the permuted word.
interface perm5_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_x;
    logic [13:0] in_p;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_z;

    // Producer/consumer side that drives words in and takes results out
    modport master (
        output in_valid, in_x, in_p, out_ready,
        input  in_ready, out_valid, out_z
    );

    // Engine side
    modport slave (
        input  in_valid, in_x, in_p, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/perm5_engine.sv
// perm5_engine: PERM5 butterfly permutation of a 5-bit word under a 14-bit
// control word, through 7 fixed two-pair swap stages.
// MODE=0 builds an iterative engine that applies one stage per clock (8 clocks
// per word). MODE=1 builds a 7-slot pipeline that accepts one word per clock.
// Both variants register every output, so there is no path from in_* to out_*.
// The only combinational path is out_ready -> in_ready.
module perm5_engine #(
    parameter int MODE = 0,
    parameter int X_W  = 5,
    parameter int P_W  = 14
) (
    input  logic     clk,
    input  logic     rst,
    perm5_if.slave   bus,
    output logic     busy
);

    // The butterfly table only exists for a 5-bit word and a 14-bit control word
    if (X_W != 5 || P_W != 14) begin : g_bad_width
        $error("perm5_engine: X_W must be 5 and P_W must be 14");
    end

    if (MODE != 0 && MODE != 1) begin : g_bad_mode
        $error("perm5_engine: MODE must be 0 or 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Swap bits a and b of x when en is set
    function automatic logic [4:0] swap_if(input logic [4:0] x, input logic [2:0] a,
                                           input logic [2:0] b, input logic en);
        logic [4:0] r;
        r = x;
        if (en) begin
            r[a] = x[b];
            r[b] = x[a];
        end
        return r;
    endfunction

    // One butterfly stage. The two pairs in a stage are disjoint, so their order does not matter.
    function automatic logic [4:0] apply_stage(input logic [2:0] s, input logic [4:0] x,
                                               input logic [13:0] p);
        logic [4:0] r;
        r = x;
        case (s)
            3'd0: begin
                r = swap_if(r, 3'd1, 3'd2, p[13]);
                r = swap_if(r, 3'd0, 3'd3, p[12]);
            end
            3'd1: begin
                r = swap_if(r, 3'd1, 3'd3, p[11]);
                r = swap_if(r, 3'd2, 3'd4, p[10]);
            end
            3'd2: begin
                r = swap_if(r, 3'd0, 3'd3, p[9]);
                r = swap_if(r, 3'd1, 3'd4, p[8]);
            end
            3'd3: begin
                r = swap_if(r, 3'd3, 3'd4, p[7]);
                r = swap_if(r, 3'd0, 3'd2, p[6]);
            end
            3'd4: begin
                r = swap_if(r, 3'd1, 3'd3, p[5]);
                r = swap_if(r, 3'd0, 3'd4, p[4]);
            end
            3'd5: begin
                r = swap_if(r, 3'd3, 3'd4, p[3]);
                r = swap_if(r, 3'd1, 3'd2, p[2]);
            end
            3'd6: begin
                r = swap_if(r, 3'd2, 3'd3, p[1]);
                r = swap_if(r, 3'd0, 3'd1, p[0]);
            end
            default: r = x;
        endcase
        return r;
    endfunction

    logic           in_ready_w;
    logic           out_valid_w;
    logic [X_W-1:0] out_z_w;
    logic           busy_w;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_z     = out_z_w;
    assign busy          = busy_w;

    if (MODE == 0) begin : g_iter
        state_t         state_q, state_d;
        logic [X_W-1:0] x_q, x_d;
        logic [P_W-1:0] p_q, p_d;
        logic [2:0]     stg_q, stg_d;

        // State, working word, control word and stage counter registers
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= IDLE;
                x_q     <= '0;
                p_q     <= '0;
                stg_q   <= '0;
            end else begin
                state_q <= state_d;
                x_q     <= x_d;
                p_q     <= p_d;
                stg_q   <= stg_d;
            end
        end

        // Next-state logic: accept, then one stage per clock, then hold the result until it is taken
        always_comb begin
            state_d     = state_q;
            x_d         = x_q;
            p_d         = p_q;
            stg_d       = stg_q;
            in_ready_w  = 1'b0;
            out_valid_w = 1'b0;
            case (state_q)
                IDLE: begin
                    in_ready_w = 1'b1;
                    if (bus.in_valid) begin
                        x_d     = bus.in_x;
                        p_d     = bus.in_p;
                        stg_d   = 3'd0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    x_d = apply_stage(stg_q, x_q, p_q);
                    if (stg_q == 3'd6) begin
                        state_d = DONE;
                    end else begin
                        stg_d = stg_q + 3'd1;
                    end
                end
                DONE: begin
                    out_valid_w = 1'b1;
                    in_ready_w  = bus.out_ready;
                    if (bus.out_ready) begin
                        if (bus.in_valid) begin
                            x_d     = bus.in_x;
                            p_d     = bus.in_p;
                            stg_d   = 3'd0;
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign out_z_w = x_q;
        assign busy_w  = (state_q != IDLE);
    end else begin : g_pipe
        // Slot 6 is the output register and never feeds a later stage, so it needs no control word
        logic [6:0]     v_q, v_d;
        logic [X_W-1:0] x_q [7];
        logic [X_W-1:0] x_d [7];
        logic [P_W-1:0] p_q [6];
        logic [P_W-1:0] p_d [6];
        logic           adv;

        // Slot registers. All slots shift together or all hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
                for (int i = 0; i < 7; i++) begin
                    x_q[i] <= '0;
                end
                for (int i = 0; i < 6; i++) begin
                    p_q[i] <= '0;
                end
            end else begin
                v_q <= v_d;
                x_q <= x_d;
                p_q <= p_d;
            end
        end

        // Advance when the output slot is empty or being taken. Each slot applies its own stage on the way in.
        always_comb begin
            adv = ~v_q[6] | bus.out_ready;
            v_d = v_q;
            x_d = x_q;
            p_d = p_q;
            if (adv) begin
                v_d[0] = bus.in_valid;
                x_d[0] = apply_stage(3'd0, bus.in_x, bus.in_p);
                p_d[0] = bus.in_p;
                for (int i = 1; i < 7; i++) begin
                    v_d[i] = v_q[i-1];
                    x_d[i] = apply_stage(3'(i), x_q[i-1], p_q[i-1]);
                    if (i < 6) begin
                        p_d[i] = p_q[i-1];
                    end
                end
            end
        end

        assign in_ready_w  = adv;
        assign out_valid_w = v_q[6];
        assign out_z_w     = x_q[6];
        assign busy_w      = |v_q;
    end

endmodule

// File: tb/tb_perm5_engine.sv
// tb_perm5_engine: directed bench for both builds of perm5_engine.
// Hand-computed vectors exercise the identity, all-swap and single-swap cases.
// A small bit-pair reference model covers the random pipeline streams.
module tb_perm5_engine;

    logic clk = 1'b0;
    logic rst;
    logic busy0;
    logic busy1;
    int   checks   = 0;
    int   failures = 0;

    perm5_if bus0 ();
    perm5_if bus1 ();

    perm5_engine #(.MODE(0), .X_W(5), .P_W(14)) dut0 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0.slave),
        .busy (busy0)
    );

    perm5_engine #(.MODE(1), .X_W(5), .P_W(14)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1.slave),
        .busy (busy1)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Reference: walk the control bits from 13 down to 0, swapping each bit's pair
    function automatic logic [4:0] ref_perm(input logic [4:0] x, input logic [13:0] p);
        logic [4:0] r;
        logic [2:0] a;
        logic [2:0] b;
        logic       t;
        r = x;
        for (int k = 13; k >= 0; k--) begin
            case (k)
                13:      {a, b} = {3'd1, 3'd2};
                12:      {a, b} = {3'd0, 3'd3};
                11:      {a, b} = {3'd1, 3'd3};
                10:      {a, b} = {3'd2, 3'd4};
                9:       {a, b} = {3'd0, 3'd3};
                8:       {a, b} = {3'd1, 3'd4};
                7:       {a, b} = {3'd3, 3'd4};
                6:       {a, b} = {3'd0, 3'd2};
                5:       {a, b} = {3'd1, 3'd3};
                4:       {a, b} = {3'd0, 3'd4};
                3:       {a, b} = {3'd3, 3'd4};
                2:       {a, b} = {3'd1, 3'd2};
                1:       {a, b} = {3'd2, 3'd3};
                default: {a, b} = {3'd0, 3'd1};
            endcase
            if (p[k]) begin
                t    = r[a];
                r[a] = r[b];
                r[b] = t;
            end
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int mode, input logic valid, input logic [4:0] x,
                                 input logic [13:0] p, input logic ordy);
        if (mode == 0) begin
            bus0.in_valid  = valid;
            bus0.in_x      = x;
            bus0.in_p      = p;
            bus0.out_ready = ordy;
        end else begin
            bus1.in_valid  = valid;
            bus1.in_x      = x;
            bus1.in_p      = p;
            bus1.out_ready = ordy;
        end
    endtask

    // One word through the iterative engine: latency, busy, stall hold, then release
    task automatic runMode0(input string tag, input logic [4:0] x, input logic [13:0] p, input logic [4:0] want);
        int   lat;
        logic ir_seen;
        applyStimulus(0, 1'b1, x, p, 1'b0);
        #1;
        checkOutput({tag, " idle in_ready"}, 32'(bus0.in_ready), 32'd1);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);
        lat     = 0;
        ir_seen = 1'b0;
        while (bus0.out_valid !== 1'b1 && lat < 20) begin
            ir_seen = ir_seen | bus0.in_ready;
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'd7);
        checkOutput({tag, " in_ready during run"}, 32'(ir_seen), 32'd0);
        checkOutput({tag, " out_z"}, 32'(bus0.out_z), 32'(want));
        checkOutput({tag, " busy"}, 32'(busy0), 32'd1);
        checkOutput({tag, " in_ready stalled"}, 32'(bus0.in_ready), 32'd0);
        tick();
        tick();
        checkOutput({tag, " held out_z"}, 32'(bus0.out_z), 32'(want));
        checkOutput({tag, " held out_valid"}, 32'(bus0.out_valid), 32'd1);
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b1);
        #1;
        checkOutput({tag, " done in_ready"}, 32'(bus0.in_ready), 32'd1);
        tick();
        checkOutput({tag, " drained out_valid"}, 32'(bus0.out_valid), 32'd0);
        checkOutput({tag, " drained busy"}, 32'(busy0), 32'd0);
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);
    endtask

    // Stream words through the pipeline while a queue of expected results tracks order
    task automatic streamMode1(input string tag, input int nwords, input bit random_stall);
        logic [4:0]  exp_q [$];
        logic [4:0]  dir_x [4];
        logic [13:0] dir_p [4];
        logic [4:0]  dir_z [4];
        logic [4:0]  cur_x;
        logic [13:0] cur_p;
        logic [4:0]  cur_want;
        logic [4:0]  front;
        logic [4:0]  held_z;
        logic        vin;
        logic        ordy;
        logic        stalled;
        int          sent;
        int          got;
        int          it;
        int          first_out;
        int          last_out;
        logic        stray;
        dir_x = '{5'b10110, 5'b00001, 5'b00001, 5'b00010};
        dir_p = '{14'h0000, 14'h3FFF, 14'h0001, 14'h2000};
        dir_z = '{5'b10110, 5'b01000, 5'b00010, 5'b00100};
        sent      = 0;
        got       = 0;
        it        = 0;
        first_out = -1;
        last_out  = -1;
        stalled   = 1'b0;
        held_z    = 5'd0;
        while (got < nwords && it < 1000) begin
            vin  = (sent < nwords) && (!random_stall || $urandom_range(0, 3) != 0);
            ordy = !random_stall || ($urandom_range(0, 1) == 1);
            cur_x    = 5'd0;
            cur_p    = 14'd0;
            cur_want = 5'd0;
            if (vin) begin
                if (sent < 4) begin
                    cur_x    = dir_x[sent];
                    cur_p    = dir_p[sent];
                    cur_want = dir_z[sent];
                end else begin
                    cur_x    = 5'($urandom_range(0, 31));
                    cur_p    = 14'($urandom);
                    cur_want = ref_perm(cur_x, cur_p);
                end
            end
            applyStimulus(1, vin, cur_x, cur_p, ordy);
            #1;
            if (stalled) begin
                checkOutput({tag, " stall holds out_z"}, 32'(bus1.out_z), 32'(held_z));
                checkOutput({tag, " stall holds out_valid"}, 32'(bus1.out_valid), 32'd1);
            end
            if (random_stall && bus1.out_valid === 1'b1) begin
                checkOutput({tag, " in_ready with full output"}, 32'(bus1.in_ready), 32'(ordy));
            end
            if (vin && bus1.in_ready === 1'b1) begin
                exp_q.push_back(cur_want);
                sent++;
            end
            if (bus1.out_valid === 1'b1 && ordy) begin
                if (exp_q.size() == 0) begin
                    checkOutput({tag, " spurious word"}, 32'(exp_q.size()), 32'd1);
                end else begin
                    front = exp_q.pop_front();
                    checkOutput({tag, " data"}, 32'(bus1.out_z), 32'(front));
                end
                got++;
                if (first_out < 0) begin
                    first_out = it;
                end
                last_out = it;
            end
            stalled = (bus1.out_valid === 1'b1) && !ordy;
            held_z  = bus1.out_z;
            tick();
            it++;
        end
        checkOutput({tag, " words delivered"}, 32'(got), 32'(nwords));
        checkOutput({tag, " words left over"}, 32'(exp_q.size()), 32'd0);
        if (!random_stall) begin
            checkOutput({tag, " first output cycle"}, 32'(first_out), 32'd7);
            checkOutput({tag, " back-to-back span"}, 32'(last_out - first_out), 32'(nwords - 1));
        end
        applyStimulus(1, 1'b0, 5'd0, 14'd0, 1'b1);
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            stray = stray | bus1.out_valid;
            tick();
        end
        checkOutput({tag, " no duplicate after drain"}, 32'(stray), 32'd0);
        checkOutput({tag, " idle busy"}, 32'(busy1), 32'd0);
        applyStimulus(1, 1'b0, 5'd0, 14'd0, 1'b0);
    endtask

    // Linear directed sequence
    initial begin
        int   lat;
        logic stray;

        rst = 1'b1;
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);
        applyStimulus(1, 1'b0, 5'd0, 14'd0, 1'b0);
        tick();
        tick();
        checkOutput("reset m0 out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("reset m0 out_z", 32'(bus0.out_z), 32'd0);
        checkOutput("reset m0 busy", 32'(busy0), 32'd0);
        checkOutput("reset m1 out_valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("reset m1 out_z", 32'(bus1.out_z), 32'd0);
        checkOutput("reset m1 busy", 32'(busy1), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset m0 in_ready", 32'(bus0.in_ready), 32'd1);
        checkOutput("reset m1 in_ready", 32'(bus1.in_ready), 32'd1);

        $display("[TB] iterative engine, directed words");
        runMode0("m0 identity",   5'b10110, 14'h0000, 5'b10110);
        runMode0("m0 all swap",   5'b00001, 14'h3FFF, 5'b01000);
        runMode0("m0 p0 only",    5'b00001, 14'h0001, 5'b00010);
        runMode0("m0 p13 only",   5'b00010, 14'h2000, 5'b00100);
        runMode0("m0 all swap 2", 5'b11000, 14'h3FFF, 5'b00110);
        runMode0("m0 p10 only",   5'b00100, 14'h0400, 5'b10000);

        $display("[TB] iterative engine, back-to-back accept from DONE");
        applyStimulus(0, 1'b1, 5'b00001, 14'h3FFF, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("b2b first latency", 32'(lat), 32'd7);
        checkOutput("b2b first out_z", 32'(bus0.out_z), 32'b01000);
        applyStimulus(0, 1'b1, 5'b00010, 14'h2000, 1'b1);
        #1;
        checkOutput("b2b in_ready follows out_ready", 32'(bus0.in_ready), 32'd1);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);
        checkOutput("b2b no bubble busy", 32'(busy0), 32'd1);
        checkOutput("b2b running in_ready", 32'(bus0.in_ready), 32'd0);
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        checkOutput("b2b second latency", 32'(lat), 32'd7);
        checkOutput("b2b second out_z", 32'(bus0.out_z), 32'b00100);
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b1);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);

        $display("[TB] pipelined engine, streaming");
        streamMode1("m1 stream", 20, 1'b0);
        streamMode1("m1 stall", 40, 1'b1);

        $display("[TB] reset in the middle of a run");
        applyStimulus(0, 1'b1, 5'b10110, 14'h3FFF, 1'b0);
        tick();
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);
        tick();
        tick();
        tick();
        checkOutput("m0 pre-reset busy", 32'(busy0), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("m0 mid-run reset out_valid", 32'(bus0.out_valid), 32'd0);
        checkOutput("m0 mid-run reset busy", 32'(busy0), 32'd0);
        checkOutput("m0 mid-run reset in_ready", 32'(bus0.in_ready), 32'd1);
        rst = 1'b0;
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b1);
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            stray = stray | bus0.out_valid;
        end
        checkOutput("m0 no stale word", 32'(stray), 32'd0);
        applyStimulus(0, 1'b0, 5'd0, 14'd0, 1'b0);

        $display("[TB] reset with a full pipeline");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1'b1, 5'(i + 1), 14'h1555, 1'b0);
            tick();
        end
        applyStimulus(1, 1'b0, 5'd0, 14'd0, 1'b0);
        #1;
        checkOutput("m1 full out_valid", 32'(bus1.out_valid), 32'd1);
        checkOutput("m1 full in_ready", 32'(bus1.in_ready), 32'd0);
        checkOutput("m1 full out_z", 32'(bus1.out_z), 32'(ref_perm(5'd1, 14'h1555)));
        rst = 1'b1;
        tick();
        checkOutput("m1 full reset out_valid", 32'(bus1.out_valid), 32'd0);
        checkOutput("m1 full reset busy", 32'(busy1), 32'd0);
        checkOutput("m1 full reset in_ready", 32'(bus1.in_ready), 32'd1);
        rst = 1'b0;
        applyStimulus(1, 1'b0, 5'd0, 14'd0, 1'b1);
        stray = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            stray = stray | bus1.out_valid;
        end
        checkOutput("m1 no stale word", 32'(stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
